// File: rtl/alu_flag_unit_pkg.sv
// Shared definitions for the ALU flag unit: branch condition codes, trap FSM states, flag payload.
package alu_flag_unit_pkg;

  localparam int unsigned COND_W = 3;

  localparam logic [COND_W-1:0] COND_NEVER  = 3'b000;
  localparam logic [COND_W-1:0] COND_EQ     = 3'b001;
  localparam logic [COND_W-1:0] COND_NE     = 3'b010;
  localparam logic [COND_W-1:0] COND_LT     = 3'b011;
  localparam logic [COND_W-1:0] COND_GE     = 3'b100;
  localparam logic [COND_W-1:0] COND_VS     = 3'b101;
  localparam logic [COND_W-1:0] COND_VC     = 3'b110;
  localparam logic [COND_W-1:0] COND_ALWAYS = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } trap_state_e;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

endpackage

// File: rtl/br_cond_eval.sv
// Purely combinational branch condition evaluator on a {z,v,n} flag set; shared with branch-target logic.
module br_cond_eval
  import alu_flag_unit_pkg::*;
(
  input  logic              z,
  input  logic              v,
  input  logic              n,
  input  logic [COND_W-1:0] cond,
  output logic              taken_c
);

  always_comb begin
    taken_c = 1'b0;
    case (cond)
      COND_NEVER:  taken_c = 1'b0;
      COND_EQ:     taken_c = z;
      COND_NE:     taken_c = ~z;
      COND_LT:     taken_c = n;
      COND_GE:     taken_c = ~n;
      COND_VS:     taken_c = v;
      COND_VC:     taken_c = ~v;
      COND_ALWAYS: taken_c = 1'b1;
      default:     taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_unit.sv
// ALU flag status register, flag-conditioned branch resolution, overflow counter and overflow trap handshake.
// Define ALU_FLAG_FWD_EN to let a same-cycle flag write feed the branch decision (fused compare-and-branch).
module alu_flag_unit
  import alu_flag_unit_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter bit          CNT_SAT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             zin,
  input  logic             vin,
  input  logic             nin,
  input  logic             flag_we,
  input  logic             br_en,
  input  logic [2:0]       br_cond,
  input  logic             trap_en,
  input  logic             trap_ack,
  input  logic             cnt_clr,
  output logic             zflag,
  output logic             vflag,
  output logic             nflag,
  output logic             br_taken,
  output logic             trap_req,
  output logic [CNT_W-1:0] ovf_cnt
);

  flags_t           flags_q, flags_d, flags_in, br_flags;
  trap_state_e      state_q, state_d;
  logic             trap_req_q, trap_req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_evt;
  logic             cond_hit;

  assign flags_in = {zin, vin, nin};
  assign ovf_evt  = flag_we & vin;

`ifdef ALU_FLAG_FWD_EN
  assign br_flags = flag_we ? flags_in : flags_q;
`else
  assign br_flags = flags_q;
`endif

  br_cond_eval u_br_cond_eval (
    .z       (br_flags.z),
    .v       (br_flags.v),
    .n       (br_flags.n),
    .cond    (br_cond),
    .taken_c (cond_hit)
  );

  assign br_taken = br_en & cond_hit;

  // Flag register, counter and trap FSM next-state
  always_comb begin
    flags_d    = flags_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    trap_req_d = 1'b0;

    if (flag_we) flags_d = flags_in;

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (ovf_evt) begin
      if (&cnt_q) cnt_d = CNT_SAT ? cnt_q : '0;
      else        cnt_d = cnt_q + CNT_W'(1);
    end

    // Events outside IDLE are counted only; they never queue a request
    case (state_q)
      IDLE:    if (ovf_evt && trap_en) state_d = REQ;
      REQ:     if (trap_ack)           state_d = DONE;
      DONE:    if (!trap_ack)          state_d = IDLE;
      default:                         state_d = IDLE;
    endcase

    trap_req_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      trap_req_q <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      trap_req_q <= trap_req_d;
    end
  end

  assign zflag    = flags_q.z;
  assign vflag    = flags_q.v;
  assign nflag    = flags_q.n;
  assign trap_req = trap_req_q;
  assign ovf_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Self-checking bench for alu_flag_unit: behavioural model with per-cycle compare, directed pins, random stimulus.
module tb_alu_flag_unit;

  localparam int unsigned CW     = 2;
  localparam int          CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          zin = 1'b0, vin = 1'b0, nin = 1'b0;
  logic          flag_we = 1'b0, br_en = 1'b0;
  logic [2:0]    br_cond = 3'd0;
  logic          trap_en = 1'b0, trap_ack = 1'b0, cnt_clr = 1'b0;

  logic          zflag, vflag, nflag, br_taken, trap_req;
  logic [CW-1:0] ovf_cnt;
  logic          w_zflag, w_vflag, w_nflag, w_br_taken, w_trap_req;
  logic [CW-1:0] w_ovf_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  // Model state
  bit m_z = 0, m_v = 0, m_n = 0;
  int m_cnt_sat = 0, m_cnt_wrap = 0;
  bit m_req = 0, m_wait_drop = 0;

  alu_flag_unit #(.CNT_W(CW), .CNT_SAT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .zin(zin), .vin(vin), .nin(nin),
    .flag_we(flag_we), .br_en(br_en), .br_cond(br_cond),
    .trap_en(trap_en), .trap_ack(trap_ack), .cnt_clr(cnt_clr),
    .zflag(zflag), .vflag(vflag), .nflag(nflag), .br_taken(br_taken),
    .trap_req(trap_req), .ovf_cnt(ovf_cnt)
  );

  alu_flag_unit #(.CNT_W(CW), .CNT_SAT(1'b0)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .zin(zin), .vin(vin), .nin(nin),
    .flag_we(flag_we), .br_en(br_en), .br_cond(br_cond),
    .trap_en(trap_en), .trap_ack(trap_ack), .cnt_clr(cnt_clr),
    .zflag(w_zflag), .vflag(w_vflag), .nflag(w_nflag), .br_taken(w_br_taken),
    .trap_req(w_trap_req), .ovf_cnt(w_ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit cond_true(input bit z, input bit v, input bit n, input logic [2:0] c);
    case (c)
      3'd0: return 1'b0;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return v;
      3'd6: return !v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit exp_taken();
    bit z, v, n;
    z = m_z; v = m_v; n = m_n;
`ifdef ALU_FLAG_FWD_EN
    if (flag_we) begin z = zin; v = vin; n = nin; end
`endif
    return br_en && cond_true(z, v, n, br_cond);
  endfunction

  // Reference model: advances on each accepted edge from the spec's rules
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_z <= 0; m_v <= 0; m_n <= 0;
      m_cnt_sat <= 0; m_cnt_wrap <= 0;
      m_req <= 0; m_wait_drop <= 0;
    end else begin
      if (flag_we) begin m_z <= zin; m_v <= vin; m_n <= nin; end
      if (cnt_clr) begin
        m_cnt_sat  <= 0;
        m_cnt_wrap <= 0;
      end else if (flag_we && vin) begin
        m_cnt_sat  <= (m_cnt_sat == CNTMAX) ? CNTMAX : m_cnt_sat + 1;
        m_cnt_wrap <= (m_cnt_wrap + 1) % (CNTMAX + 1);
      end
      if (m_req) begin
        if (trap_ack) begin m_req <= 0; m_wait_drop <= 1; end
      end else if (m_wait_drop) begin
        if (!trap_ack) m_wait_drop <= 0;
      end else if (flag_we && vin && trap_en) begin
        m_req <= 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("zflag", int'(zflag), int'(m_z));
      chk("vflag", int'(vflag), int'(m_v));
      chk("nflag", int'(nflag), int'(m_n));
      chk("br_taken", int'(br_taken), int'(exp_taken()));
      chk("trap_req", int'(trap_req), int'(m_req));
      chk("ovf_cnt_sat", int'(ovf_cnt), m_cnt_sat);
      chk("ovf_cnt_wrap", int'(w_ovf_cnt), m_cnt_wrap);
      chk("wrap_trap_req", int'(w_trap_req), int'(m_req));
      chk("wrap_br_taken", int'(w_br_taken), int'(br_taken));
      chk("wrap_flags", int'({w_zflag, w_vflag, w_nflag}), int'({m_z, m_v, m_n}));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    zin = 0; vin = 0; nin = 0; flag_we = 0; br_en = 0; br_cond = 3'd0;
    trap_en = 0; trap_ack = 0; cnt_clr = 0;
  endtask

  initial begin
    #3;
    chk("reset_zflag", int'(zflag), 0);
    chk("reset_trap_req", int'(trap_req), 0);
    chk("reset_ovf_cnt", int'(ovf_cnt), 0);
    #9 rst_n = 1;
    check_en = 1;

    // Reset-state branches
    br_en = 1; br_cond = 3'b111; #1;
    chk("reset_always", int'(br_taken), 1);
    br_cond = 3'b001; #1;
    chk("reset_eq", int'(br_taken), 0);
    br_en = 0;

    // Flag write then branch
    step();
    flag_we = 1; zin = 1; vin = 0; nin = 0;
    step();
    flag_we = 0; zin = 0; br_en = 1; br_cond = 3'b001; #1;
    chk("wr_zflag", int'(zflag), 1);
    chk("wr_eq", int'(br_taken), 1);
    br_cond = 3'b010; #1;
    chk("wr_ne", int'(br_taken), 0);
    br_en = 0;

    // Same-cycle flag write and branch
    step();
    flag_we = 1; zin = 0;
    step();
    flag_we = 1; zin = 1; br_en = 1; br_cond = 3'b001; #1;
`ifdef ALU_FLAG_FWD_EN
    chk("fused_eq", int'(br_taken), 1);
`else
    chk("fused_eq", int'(br_taken), 0);
`endif
    step();
    clear_inputs();
    #1;
    chk("fused_zflag", int'(zflag), 1);

    // Trap handshake
    cnt_clr = 1;
    step();
    cnt_clr = 0; trap_en = 1; flag_we = 1; vin = 1;
    step();
    flag_we = 0; vin = 0;
    chk("trap_req_set", int'(trap_req), 1);
    chk("trap_cnt1", int'(ovf_cnt), 1);
    flag_we = 1; vin = 1;
    step();
    flag_we = 0; vin = 0;
    chk("trap_cnt2", int'(ovf_cnt), 2);
    chk("trap_single_req", int'(trap_req), 1);
    trap_ack = 1;
    step();
    chk("trap_ack_drop", int'(trap_req), 0);
    flag_we = 1; vin = 1;
    step();
    flag_we = 0; vin = 0;
    chk("done_no_new_req", int'(trap_req), 0);
    chk("done_cnt3", int'(ovf_cnt), 3);
    trap_ack = 0;
    step();
    chk("back_idle", int'(trap_req), 0);
    flag_we = 1; vin = 1;
    step();
    flag_we = 0; vin = 0;
    chk("idle_rearm", int'(trap_req), 1);
    chk("sat_hold", int'(ovf_cnt), 3);
    chk("wrap_zero", int'(w_ovf_cnt), 0);
    trap_ack = 1;
    step();
    trap_ack = 0;
    step();
    clear_inputs();

    // Counter boundary
    cnt_clr = 1;
    step();
    cnt_clr = 0; flag_we = 1; vin = 1;
    repeat (4) step();
    flag_we = 0; vin = 0;
    chk("four_sat", int'(ovf_cnt), 3);
    chk("four_wrap", int'(w_ovf_cnt), 0);
    flag_we = 1; vin = 1; cnt_clr = 1;
    step();
    clear_inputs();
    chk("clr_wins_sat", int'(ovf_cnt), 0);
    chk("clr_wins_wrap", int'(w_ovf_cnt), 0);

    // Reset during REQ
    trap_en = 1; flag_we = 1; vin = 1;
    step();
    clear_inputs();
    chk("pre_rst_req", int'(trap_req), 1);
    #1 rst_n = 0;
    #1;
    chk("rst_req_clear", int'(trap_req), 0);
    chk("rst_cnt_clear", int'(ovf_cnt), 0);
    #1 rst_n = 1;
    trap_ack = 1;
    step();
    chk("ack_after_rst", int'(trap_req), 0);
    trap_ack = 0;
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      zin      = 1'($urandom_range(0, 1));
      nin      = 1'($urandom_range(0, 1));
      vin      = ($urandom_range(0, 2) == 0);
      flag_we  = 1'($urandom_range(0, 1));
      br_en    = 1'($urandom_range(0, 1));
      br_cond  = 3'($urandom_range(0, 7));
      trap_en  = 1'($urandom_range(0, 1));
      cnt_clr  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) trap_ack = ~trap_ack;
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 0;
        #1 rst_n = 1;
      end
    end

    step();
    clear_inputs();
    step();
    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_flag_unit.md
Name: alu_flag_unit

Overview:
- Downstream consumer of the 32-bit ALU's zout/vout/nout flags in the single-cycle MIPS-lite datapath.
- Latches the flags into a status register and resolves flag-based conditional branches from them.
- Counts overflow events.
- Raises an overflow trap request to the control unit using a 4-phase req/ack handshake.

Parameters:
- CNT_W, 8, width of the overflow event counter.
- CNT_SAT, 1, 1 = counter saturates at all-ones; 0 = counter wraps to 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- zin  input  1  ALU zero flag (zout) for the current instruction.
- vin  input  1  ALU overflow flag (vout).
- nin  input  1  ALU negative flag (nout).
- flag_we  input  1  current instruction updates flags (ADD/SUB/SLT class).
- br_en  input  1  current instruction is a flag-conditioned branch.
- br_cond  input  3  branch condition select.
- trap_en  input  1  overflow trap enable.
- trap_ack  input  1  control unit acknowledge of trap_req.
- cnt_clr  input  1  synchronous clear of ovf_cnt.
- zflag  output  1  registered Z.
- vflag  output  1  registered V.
- nflag  output  1  registered N.
- br_taken  output  1  branch decision, combinational.
- trap_req  output  1  overflow trap request, registered.
- ovf_cnt  output  CNT_W  overflow event count.

Behaviour:
- Reset (rst_n=0, asynchronous): zflag=0, vflag=0, nflag=0, trap_req=0, ovf_cnt=0, FSM=IDLE. br_taken is therefore 0 for every condition except ALWAYS.
- Flag register:
  - On a rising edge with flag_we=1: {zflag,vflag,nflag} <= {zin,vin,nin}.
  - With flag_we=0 the flags hold.
  - Write latency 1 cycle.
- Branch conditions (br_cond):
  - 000 NEVER; 001 EQ (Z); 010 NE (!Z); 011 LT (N); 100 GE (!N); 101 VS (V); 110 VC (!V); 111 ALWAYS.
  - br_taken = br_en & cond(registered flags). br_taken=0 whenever br_en=0.
- Simultaneous flag_we and br_en: the branch uses the registered (previous) flags, except as modified by FLAG_FWD_EN.
- Overflow event: flag_we=1 and vin=1 in a cycle.
- Counter:
  - Each overflow event adds 1 to ovf_cnt.
  - At all-ones: holds if CNT_SAT=1, wraps to 0 if CNT_SAT=0.
  - cnt_clr=1 in the same cycle as an event: clear wins, result 0.
- Trap FSM states:
  - IDLE: trap_req=0. Overflow event with trap_en=1 moves to REQ on the next edge.
  - REQ: trap_req=1. Holds until trap_ack=1, then moves to DONE.
  - DONE: trap_req=0. Holds until trap_ack=0, then moves to IDLE.
- Overflow events in REQ or DONE:
  - Counted, but create no additional request.
  - Not queued.
- trap_ack seen in IDLE is ignored.
- trap_en is sampled only in IDLE. Deasserting it in REQ does not withdraw the request.
- Reset asserted mid-handshake: immediate return to IDLE with trap_req=0. ovf_cnt is lost.

Optional Feature:
- Macro: ALU_FLAG_FWD_EN.
- Defined: when flag_we=1 and br_en=1 in the same cycle, br_cond is evaluated on the incoming {zin,vin,nin}. This supports a fused compare-and-branch. The registered update is unchanged.
- Undefined: br_taken always uses the registered flags.

Decomposition:
- Shared package holds:
  - Condition-code constants COND_NEVER..COND_ALWAYS (3-bit).
  - FSM state encoding IDLE=2'b00, REQ=2'b01, DONE=2'b10.
- Sub-module br_cond_eval: purely combinational {z,v,n,cond} -> taken. It is reused by the branch-target logic.

Test Plan:
- Reset then hold: rst_n=0 asserted mid-cycle -> all outputs 0 immediately. br_en=1, br_cond=111 -> br_taken=1; br_cond=001 -> br_taken=0.
- Flag write then branch: flag_we=1, zin=1, vin=0, nin=0; next cycle br_en=1, br_cond=001 -> br_taken=1; br_cond=010 -> br_taken=0.
- Same-cycle flag_we and branch: registered Z=0, zin=1, br_cond=001 -> br_taken=0 without the macro, 1 with ALU_FLAG_FWD_EN.
- Trap handshake:
  - trap_en=1, flag_we=1, vin=1 -> trap_req=1 the next cycle.
  - A second overflow while in REQ -> ovf_cnt=2, still a single request.
  - trap_ack=1 -> trap_req=0, state DONE.
  - trap_ack=0 -> IDLE.
- Counter boundary, CNT_W=2:
  - 4 events with CNT_SAT=1 -> ovf_cnt=3.
  - With CNT_SAT=0 -> ovf_cnt=0.
  - cnt_clr coincident with an event -> 0.
- Reset during REQ: rst_n pulsed low -> trap_req=0 and ovf_cnt=0 at once. A following trap_ack is ignored.
